// File: rtl/imem_responder_if.sv
// Fetch-side bus between the PC block (master) and the instruction memory
// responder (slave). Addresses and words are numbered [0:31], bit 0 = MSB.
interface imem_responder_if;
  logic        addr_valid;
  logic [0:31] addr;
  logic        addr_ready;
  logic        inst_valid;
  logic [0:31] inst;
  logic        inst_err;
  logic        inst_ready;
  logic        flush;

  modport master (
    output addr_valid, addr, inst_ready, flush,
    input  addr_ready, inst_valid, inst, inst_err
  );

  modport slave (
    input  addr_valid, addr, inst_ready, flush,
    output addr_ready, inst_valid, inst, inst_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch address over a valid/ready
// handshake and returns the addressed word WAIT_STATES cycles later. Supports
// flush, a side load port, and misaligned / out-of-range error reporting.
module imem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [0:31] NOP_WORD    = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_responder_if.slave      bus,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [0:31]          ld_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [0:31] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:31] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [0:31] inst_q, inst_d;
  logic        err_q, err_d;

  logic                 addr_ready;
  logic                 accept;
  logic [0:31]          rd_addr;
  logic [ADDR_BITS-1:0] rd_idx;
  logic                 rd_err;
  logic [0:31]          rd_word;

  assign addr_ready = !bus.flush &&
                      ((state_q == S_IDLE) || ((state_q == S_RESP) && bus.inst_ready));
  assign accept     = bus.addr_valid && addr_ready;

  // Address looked up on the edge entering RESP: the latched address when
  // leaving WAIT, otherwise the address being accepted right now (zero-wait).
  assign rd_addr = (state_q == S_WAIT) ? addr_q : bus.addr;
  assign rd_idx  = rd_addr[30-ADDR_BITS:29];
  assign rd_err  = (rd_addr[30:31] != 2'b00) || (|rd_addr[0:29-ADDR_BITS]);
  assign rd_word = rd_err ? NOP_WORD : mem[rd_idx];

  // Next-state logic for the fetch FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    err_d   = err_q;

    if (bus.flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            valid_d = 1'b1;
            cnt_d   = '0;
            inst_d  = rd_word;
            err_d   = rd_err;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.inst_ready && !accept) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase

      // Shared by IDLE and back-to-back acceptance from RESP.
      if (accept) begin
        addr_d = bus.addr;
        if (WAIT_STATES == 0) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          cnt_d   = '0;
          inst_d  = rd_word;
          err_d   = rd_err;
        end else begin
          state_d = S_WAIT;
          valid_d = 1'b0;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
    end
  end

  // FSM state and output registers; reset overrides flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      inst_q  <= NOP_WORD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Load port write; contents survive reset. Same-edge reads see the old word.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign bus.addr_ready = addr_ready;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_err   = err_q;

endmodule
